tlu_readout_arbiter: RTL and testbench

- Shares one 16-bit downstream FIFO read port between N_SRC upstream 16-bit FIFO-style sources.
- Source 0 is the TLU master record stream: 8 words per trigger, with FIFO_EMPTY low for words 1..7.
- A granted source keeps the port for its full burst, so TLU records are never interleaved with other data.
- Sits between the TLU master core, other readout FIFOs, and the fast readout path on BUS_CLK.

---
 rtl/tlu_readout_arbiter.sv | 135 +++++++++++++
 tb/tb_tlu_readout_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlu_readout_arbiter.sv
// Round-robin arbiter that shares one 16-bit FIFO read port between N_SRC
// FIFO-style sources. A grant is held for a whole burst, so a TLU record from
// source 0 (SRC0_WORDS words) is never interleaved with data from other sources.
//
// Ports:
//   BUS_CLK    clock
//   RST        synchronous active-high reset
//   EN         per-source arbitration enable
//   SRC_EMPTY  per-source empty flag
//   SRC_DATA   per-source current word, source i at [16i+15:16i]
//   SRC_READ   per-source pop strobe (combinational from grant and OUT_READ)
//   OUT_READ   downstream pop
//   OUT_EMPTY  downstream empty (combinational)
//   OUT_DATA   current word of the granted source (combinational)
//   OUT_SRC    index of the granted source
//   BUSY       high while a grant is active
//   WORD_CNT   total words delivered, saturating at 16'hffff
module tlu_readout_arbiter #(
  parameter int unsigned N_SRC       = 4,
  parameter int unsigned SRC0_WORDS  = 8,
  parameter int unsigned OTHER_WORDS = 2,
  parameter int unsigned SW          = 3
) (
  input  logic                BUS_CLK,
  input  logic                RST,
  input  logic [N_SRC-1:0]    EN,
  input  logic [N_SRC-1:0]    SRC_EMPTY,
  input  logic [16*N_SRC-1:0] SRC_DATA,
  output logic [N_SRC-1:0]    SRC_READ,
  input  logic                OUT_READ,
  output logic                OUT_EMPTY,
  output logic [15:0]         OUT_DATA,
  output logic [SW-1:0]       OUT_SRC,
  output logic                BUSY,
  output logic [15:0]         WORD_CNT
);

  localparam int unsigned CW = 16;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   grant_q, grant_d;
  logic [SW-1:0]   last_q, last_d;
  logic [CW-1:0]   burst_q, burst_d;
  logic [CW-1:0]   total_q, total_d;

  logic [N_SRC-1:0] req;
  logic [SW-1:0]    pick;
  logic             found;
  logic             sel_empty;
  logic [15:0]      sel_data;
  logic [CW-1:0]    burst_len;
  logic             pop;

  // Round-robin search starting one past the last granted source.
  always_comb begin
    req   = EN & ~SRC_EMPTY;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= N_SRC; k++) begin
      int unsigned idx;
      idx = (32'(last_q) + k) % N_SRC;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = SW'(idx);
      end
    end
  end

  // Granted-source datapath and burst length.
  always_comb begin
    sel_empty = SRC_EMPTY[grant_q];
    sel_data  = SRC_DATA[{grant_q, 4'b0000} +: 16];
    burst_len = (grant_q == '0) ? CW'(SRC0_WORDS) : CW'(OTHER_WORDS);
  end

  // Next-state and port logic.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    burst_d   = burst_q;
    total_d   = total_q;
    OUT_EMPTY = 1'b1;
    OUT_DATA  = 16'h0000;
    SRC_READ  = '0;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          last_d  = pick;
          burst_d = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        OUT_EMPTY         = sel_empty;
        OUT_DATA          = sel_data;
        pop               = OUT_READ & ~sel_empty;
        SRC_READ[grant_q] = pop;
        if (pop) begin
          burst_d = burst_q + CW'(1);
          if (total_q != 16'hffff) total_d = total_q + CW'(1);
          // The pop that completes the burst hands the port back.
          if (burst_q + CW'(1) == burst_len) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= SW'(N_SRC - 1);
      burst_q <= '0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      total_q <= total_d;
    end
  end

  assign BUSY     = (state_q == GRANT);
  assign OUT_SRC  = grant_q;
  assign WORD_CNT = total_q;

endmodule

// File: tb/tb_tlu_readout_arbiter.sv
// Bench for tlu_readout_arbiter: behavioural source FIFOs, a scoreboard of
// expected (source, word) pairs, a cycle table for a single TLU record and
// hand-written sequences for the multi-cycle corner cases.
module tb_tlu_readout_arbiter;

  localparam int unsigned N = 4;

  logic          BUS_CLK = 1'b0;
  logic          RST;
  logic [N-1:0]  EN;
  logic [N-1:0]  SRC_EMPTY;
  logic [16*N-1:0] SRC_DATA;
  logic [N-1:0]  SRC_READ;
  logic          OUT_READ;
  logic          OUT_EMPTY;
  logic [15:0]   OUT_DATA;
  logic [2:0]    OUT_SRC;
  logic          BUSY;
  logic [15:0]   WORD_CNT;

  tlu_readout_arbiter #(.N_SRC(N), .SRC0_WORDS(8), .OTHER_WORDS(2), .SW(3)) dut (
    .BUS_CLK(BUS_CLK), .RST(RST), .EN(EN), .SRC_EMPTY(SRC_EMPTY),
    .SRC_DATA(SRC_DATA), .SRC_READ(SRC_READ), .OUT_READ(OUT_READ),
    .OUT_EMPTY(OUT_EMPTY), .OUT_DATA(OUT_DATA), .OUT_SRC(OUT_SRC),
    .BUSY(BUSY), .WORD_CNT(WORD_CNT)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  typedef struct {
    logic [2:0]  src;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    logic        busy;
    logic        empty;
    logic [3:0]  sread;
    logic [15:0] wcnt;
  } row_t;

  logic [15:0] srcq [N][$];
  exp_t        exp_q [$];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic drive_srcs();
    for (int i = 0; i < int'(N); i++) begin
      SRC_EMPTY[i] = (srcq[i].size() == 0);
      SRC_DATA[16*i +: 16] = (srcq[i].size() != 0) ? srcq[i][0] : 16'h0000;
    end
  endtask

  task automatic load(input int s, input int n, input logic [15:0] base, input bit scored);
    exp_t e;
    for (int k = 1; k <= n; k++) begin
      srcq[s].push_back(base + 16'(k));
      if (scored) begin
        e.src  = 3'(s);
        e.data = base + 16'(k);
        exp_q.push_back(e);
      end
    end
    drive_srcs();
  endtask

  // One clock: score the accepted word, step the edge, apply source pops.
  task automatic tick();
    logic [N-1:0] popm;
    logic         rst_seen;
    exp_t         e;
    #1;
    rst_seen = RST;
    popm     = SRC_READ;
    if (!rst_seen && OUT_READ && !OUT_EMPTY) begin
      if (exp_q.size() == 0) begin
        chk("unexpected pop", {13'h0, OUT_SRC, OUT_DATA}, 32'hffffffff);
      end else begin
        e = exp_q.pop_front();
        chk("pop data", OUT_DATA, e.data);
        chk("pop src", OUT_SRC, e.src);
        chk("pop strobe", SRC_READ, 4'(1) << e.src);
      end
    end
    @(posedge BUS_CLK);
    @(negedge BUS_CLK);
    for (int i = 0; i < int'(N); i++) begin
      if (rst_seen) srcq[i].delete();
      else if (popm[i] && srcq[i].size() != 0) void'(srcq[i].pop_front());
    end
    if (rst_seen) exp_q.delete();
    drive_srcs();
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    row_t tbl [10];
    int   ticks;
    int   idle;

    // Single TLU record: idle bubble, 8 pops, idle again.
    tbl[0] = '{busy:1'b0, empty:1'b1, sread:4'b0000, wcnt:16'd0};
    for (int r = 1; r <= 8; r++)
      tbl[r] = '{busy:1'b1, empty:1'b0, sread:4'b0001, wcnt:16'(r - 1)};
    tbl[9] = '{busy:1'b0, empty:1'b1, sread:4'b0000, wcnt:16'd8};

    RST = 1'b1; EN = '1; OUT_READ = 1'b0;
    drive_srcs();
    do_reset();
    chk("reset OUT_EMPTY", OUT_EMPTY, 1);
    chk("reset SRC_READ", SRC_READ, 0);
    chk("reset BUSY", BUSY, 0);
    chk("reset WORD_CNT", WORD_CNT, 0);
    chk("reset OUT_SRC", OUT_SRC, 0);

    // Test 1: table-driven single record.
    OUT_READ = 1'b1;
    load(0, 8, 16'h0000, 1'b1);
    #1;
    for (int r = 0; r < 10; r++) begin
      chk($sformatf("t1 busy row%0d", r), BUSY, tbl[r].busy);
      chk($sformatf("t1 empty row%0d", r), OUT_EMPTY, tbl[r].empty);
      chk($sformatf("t1 sread row%0d", r), SRC_READ, tbl[r].sread);
      chk($sformatf("t1 wcnt row%0d", r), WORD_CNT, tbl[r].wcnt);
      if (r != 9) tick();
    end
    chk("t1 drained", exp_q.size(), 0);

    // Test 2: round-robin 0,1,2,0 with one bubble per grant.
    do_reset();
    OUT_READ = 1'b1;
    load(0, 8, 16'h0000, 1'b1);
    load(1, 2, 16'h1000, 1'b1);
    load(2, 2, 16'h2000, 1'b1);
    load(0, 8, 16'h0008, 1'b1);
    #1;
    ticks = 0; idle = 0;
    while (exp_q.size() != 0 && ticks < 100) begin
      if (!BUSY) idle++;
      tick();
      ticks++;
    end
    chk("t2 cycles", ticks, 24);
    chk("t2 bubbles", idle, 4);
    chk("t2 wcnt", WORD_CNT, 20);

    // Test 3: OUT_READ toggling during a source-1 burst.
    do_reset();
    OUT_READ = 1'b1;
    load(1, 2, 16'h1000, 1'b1);
    #1;
    chk("t3 idle busy", BUSY, 0);
    tick();
    chk("t3 granted src", OUT_SRC, 1);
    chk("t3 sread on", SRC_READ, 4'b0010);
    tick();
    OUT_READ = 1'b0;
    #1;
    chk("t3 sread off", SRC_READ, 4'b0000);
    tick();
    chk("t3 hold wcnt", WORD_CNT, 1);
    chk("t3 hold busy", BUSY, 1);
    OUT_READ = 1'b1;
    #1;
    chk("t3 sread on2", SRC_READ, 4'b0010);
    tick();
    chk("t3 end busy", BUSY, 0);
    chk("t3 end wcnt", WORD_CNT, 2);

    // Test 4: source 2 runs dry mid-burst for 5 cycles.
    do_reset();
    OUT_READ = 1'b1;
    load(2, 1, 16'h2000, 1'b1);
    exp_q.push_back('{src:3'd2, data:16'h2002});
    #1;
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("t4 empty c%0d", c), OUT_EMPTY, 1);
      chk($sformatf("t4 grant c%0d", c), {BUSY, OUT_SRC}, 4'b1010);
      tick();
    end
    srcq[2].push_back(16'h2002);
    drive_srcs();
    #1;
    chk("t4 refilled", OUT_EMPTY, 0);
    tick();
    chk("t4 end busy", BUSY, 0);
    chk("t4 wcnt", WORD_CNT, 2);
    chk("t4 drained", exp_q.size(), 0);

    // Test 5: only source 1 enabled; EN cleared mid-burst.
    do_reset();
    EN = 4'b0010;
    OUT_READ = 1'b1;
    load(0, 8, 16'h0000, 1'b0);
    load(1, 2, 16'h1000, 1'b1);
    load(1, 2, 16'h1002, 1'b0);
    load(2, 2, 16'h2000, 1'b0);
    load(3, 2, 16'h3000, 1'b0);
    #1;
    tick();
    chk("t5 granted src", OUT_SRC, 1);
    tick();
    EN = 4'b0000;
    tick();
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("t5 idle c%0d", c), BUSY, 0);
      tick();
    end
    chk("t5 wcnt", WORD_CNT, 2);
    chk("t5 drained", exp_q.size(), 0);
    EN = '1;

    // Test 6: reset at word 4 of a TLU record.
    do_reset();
    OUT_READ = 1'b1;
    load(0, 8, 16'h0000, 1'b1);
    load(1, 2, 16'h1000, 1'b0);
    #1;
    tick();
    tick(); tick(); tick();
    chk("t6 word4", OUT_DATA, 16'h0004);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    chk("t6 rst empty", OUT_EMPTY, 1);
    chk("t6 rst busy", BUSY, 0);
    chk("t6 rst wcnt", WORD_CNT, 0);
    load(0, 8, 16'h0000, 1'b1);
    load(1, 2, 16'h1000, 1'b1);
    #1;
    tick();
    chk("t6 first grant", {BUSY, OUT_SRC}, 4'b1000);
    ticks = 0;
    while (exp_q.size() != 0 && ticks < 60) begin
      tick();
      ticks++;
    end
    chk("t6 drained", exp_q.size(), 0);
    chk("t6 wcnt", WORD_CNT, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
